// File: rtl/lc3b_stage_reg_pkg.sv
// Shared types for lc3b pipeline stage registers: stage FSM states and the EX/MEM payload layout.
// No logic; the one helper maps a stage state to its entry count.
// Backpressure: not applicable.
package lc3b_stage_reg_pkg;

    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_ONE   = 2'd1,
        STG_FULL  = 2'd2
    } lc3b_stage_state;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] alu_out;
        logic [15:0] sr1_data;
        logic [15:0] sr2_data;
        logic [15:0] mem_addr;
        logic [15:0] offset;
        logic [2:0]  dest;
        logic [28:0] ctrl;
    } lc3b_exmem_payload;

    localparam int EXMEM_PAYLOAD_W = $bits(lc3b_exmem_payload);
    // mem_addr sits above offset (16), dest (3) and ctrl (29)
    localparam int EXMEM_ADDR_LSB  = 48;

    function automatic logic [1:0] stage_occupancy(input lc3b_stage_state s);
        case (s)
            STG_ONE:  return 2'd1;
            STG_FULL: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lc3b_stage_reg_if.sv
// Valid/ready bus between a pipeline producer, a stage register and its consumer.
// Slave modport is the stage register side; master is the surrounding pipeline.
// Backpressure: up_ready/dn_ready carry it in each direction.
interface lc3b_stage_reg_if #(
    parameter int PAYLOAD_W = 128,
    parameter int ADDR_W    = 16
);
    logic                 up_valid;
    logic                 up_ready;
    logic [PAYLOAD_W-1:0] up_data;
    logic                 flush;
    logic                 load_addr;
    logic [ADDR_W-1:0]    next_addr;
    logic                 dn_valid;
    logic                 dn_ready;
    logic [PAYLOAD_W-1:0] dn_data;

    modport master (
        output up_valid, up_data, flush, load_addr, next_addr, dn_ready,
        input  up_ready, dn_valid, dn_data
    );

    modport slave (
        input  up_valid, up_data, flush, load_addr, next_addr, dn_ready,
        output up_ready, dn_valid, dn_data
    );

endinterface

// File: rtl/lc3b_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the clock edge after inc.
// Backpressure: none; holds at all-ones.
module lc3b_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lc3b_stage_reg.sv
// Pipeline stage register with optional 2-entry skid, flush-to-bubble and head address rewrite.
// Latency: 1 cycle from accept to dn_valid when empty; strict FIFO order.
// Backpressure: up_ready registered (SKID=1) or ~dn_valid|dn_ready combinational (SKID=0).
module lc3b_stage_reg
    import lc3b_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = 128,
    parameter int ADDR_W    = 16,
    parameter int ADDR_LSB  = 16,
    parameter int SKID      = 1
) (
    input  logic                clk,
    input  logic                reset,
    lc3b_stage_reg_if.slave     bus,
    output logic [1:0]          occupancy,
    output logic [15:0]         bubble_cnt
);

    if (ADDR_LSB + ADDR_W > PAYLOAD_W) begin : g_bad_addr_field
        $error("lc3b_stage_reg: address field exceeds payload width");
    end
    if ((SKID != 0) && (SKID != 1)) begin : g_bad_skid
        $error("lc3b_stage_reg: SKID must be 0 or 1");
    end

    lc3b_stage_state      state_q, state_d;
    logic [PAYLOAD_W-1:0] m_q, m_d;
    logic [PAYLOAD_W-1:0] s_q, s_d;
    logic                 dn_valid_w;
    logic                 accept;
    logic                 retire;
    logic                 load_ok;
    logic                 bubble_inc;

    assign dn_valid_w = (state_q != STG_EMPTY);
    assign retire     = dn_valid_w & bus.dn_ready;
    assign accept     = bus.up_valid & bus.up_ready;
    assign load_ok    = bus.load_addr & dn_valid_w & ~retire;

    assign bus.dn_valid = dn_valid_w;
    // M is forced to zero whenever the stage empties, so no output gating is needed
    assign bus.dn_data  = m_q;
    assign occupancy    = stage_occupancy(state_q);

    if (SKID == 1) begin : g_skid_ready
        logic up_ready_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                up_ready_q <= 1'b1;
            end else begin
                up_ready_q <= (state_d != STG_FULL);
            end
        end
        assign bus.up_ready = up_ready_q;
    end else begin : g_comb_ready
        assign bus.up_ready = ~dn_valid_w | bus.dn_ready;
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            STG_EMPTY: begin
                if (accept) begin
                    state_d = STG_ONE;
                    m_d     = bus.up_data;
                end
            end
            STG_ONE: begin
                if (accept && retire) begin
                    m_d = bus.up_data;
                end else if (accept && (SKID == 1)) begin
                    state_d = STG_FULL;
                    s_d     = bus.up_data;
                end else if (retire) begin
                    state_d = STG_EMPTY;
                    m_d     = '0;
                end
            end
            STG_FULL: begin
                if (retire) begin
                    state_d = STG_ONE;
                    m_d     = s_q;
                    s_d     = '0;
                end
            end
            default: begin
                state_d = STG_EMPTY;
                m_d     = '0;
                s_d     = '0;
            end
        endcase
        // load_ok excludes retire, so m_d still holds the current head here
        if (load_ok) begin
            m_d[ADDR_LSB +: ADDR_W] = bus.next_addr;
        end
        if (bus.flush) begin
            state_d = STG_EMPTY;
            m_d     = '0;
            s_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STG_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign bubble_inc = ~dn_valid_w;

    lc3b_sat_counter #(
        .WIDTH (16)
    ) u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (bubble_inc),
        .cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_lc3b_stage_reg.sv
// Bench for lc3b_stage_reg: vector table on a SKID=1 instance with an ordering scoreboard,
// plus hand sequences for combinational ready (SKID=0) and bubble counter saturation.
module tb_lc3b_stage_reg;

    localparam int PW = 48;
    localparam int AW = 16;
    localparam int AL = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3b_stage_reg_if #(.PAYLOAD_W(PW), .ADDR_W(AW)) bus1 ();
    lc3b_stage_reg_if #(.PAYLOAD_W(PW), .ADDR_W(AW)) bus0 ();

    logic [1:0]  occ1, occ0;
    logic [15:0] bub1, bub0;

    lc3b_stage_reg #(.PAYLOAD_W(PW), .ADDR_W(AW), .ADDR_LSB(AL), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .occupancy(occ1), .bubble_cnt(bub1)
    );

    lc3b_stage_reg #(.PAYLOAD_W(PW), .ADDR_W(AW), .ADDR_LSB(AL), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .occupancy(occ0), .bubble_cnt(bub0)
    );

    typedef struct {
        logic          uv;
        logic [PW-1:0] d;
        logic          dr;
        logic          fl;
        logic          ld;
        logic [AW-1:0] na;
        logic          e_dv;
        logic [PW-1:0] e_dd;
        logic          e_rdy;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t          vt[$];
    logic [PW-1:0] sbq[$];
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic uv, input logic [PW-1:0] d, input logic dr, input logic fl,
                       input logic ld, input logic [AW-1:0] na, input logic e_dv,
                       input logic [PW-1:0] e_dd, input logic e_rdy, input logic [1:0] e_occ);
        vec_t v;
        v.uv = uv; v.d = d; v.dr = dr; v.fl = fl; v.ld = ld; v.na = na;
        v.e_dv = e_dv; v.e_dd = e_dd; v.e_rdy = e_rdy; v.e_occ = e_occ;
        vt.push_back(v);
    endtask

    // One clock on dut1: scoreboard bookkeeping from the handshake seen before the edge.
    task automatic cyc();
        logic          ret;
        logic          acc;
        logic [PW-1:0] e;
        ret = bus1.dn_valid && bus1.dn_ready && !reset;
        acc = bus1.up_valid && bus1.up_ready && !bus1.flush && !reset;
        if (ret) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected nothing", bus1.dn_data);
            end else begin
                e = sbq.pop_front();
                chk("sb_order", 64'(bus1.dn_data), 64'(e));
            end
        end
        if (!reset && bus1.flush) begin
            sbq.delete();
        end else if (!reset && bus1.load_addr && bus1.dn_valid && !ret && sbq.size() > 0) begin
            e = sbq[0];
            e[AL +: AW] = bus1.next_addr;
            sbq[0] = e;
        end
        if (acc) sbq.push_back(bus1.up_data);
        @(posedge clk);
        #1;
    endtask

    task automatic step0();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // reset with garbage on the upstream side
        reset = 1'b1;
        bus1.up_valid = 1'b1; bus1.up_data = 48'hFFFF_FFFF_FFFF; bus1.dn_ready = 1'b0;
        bus1.flush = 1'b0; bus1.load_addr = 1'b0; bus1.next_addr = '0;
        bus0.up_valid = 1'b1; bus0.up_data = 48'hFFFF_FFFF_FFFF; bus0.dn_ready = 1'b0;
        bus0.flush = 1'b0; bus0.load_addr = 1'b0; bus0.next_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst dn_valid", 64'(bus1.dn_valid), 64'd0);
        chk("rst dn_data", 64'(bus1.dn_data), 64'd0);
        chk("rst up_ready", 64'(bus1.up_ready), 64'd1);
        chk("rst occupancy", 64'(occ1), 64'd0);
        chk("rst bubble_cnt", 64'(bub1), 64'd0);
        chk("rst0 dn_valid", 64'(bus0.dn_valid), 64'd0);
        chk("rst0 up_ready", 64'(bus0.up_ready), 64'd1);
        chk("rst0 bubble_cnt", 64'(bub0), 64'd0);

        reset = 1'b0;
        bus1.up_valid = 1'b0;
        bus0.up_valid = 1'b0;
        cyc();
        chk("bubble first idle", 64'(bub1), 64'd1);

        // uv d dr fl ld na | dn_valid dn_data up_ready occupancy
        add(1'b1, 48'h1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 48'h1, 1'b1, 2'd1);
        add(1'b1, 48'h2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 48'h2, 1'b1, 2'd1);
        add(1'b1, 48'h3, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 48'h3, 1'b1, 2'd1);
        add(1'b1, 48'h4, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 48'h4, 1'b1, 2'd1);
        add(1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 48'h0, 1'b1, 2'd0);
        add(1'b1, 48'h0000_AAAA_0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h0000_AAAA_0000, 1'b1, 2'd1);
        add(1'b1, 48'h0000_BBBB_0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h0000_AAAA_0000, 1'b0, 2'd2);
        add(1'b1, 48'h0000_CCCC_0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h0000_AAAA_0000, 1'b0, 2'd2);
        add(1'b1, 48'h0000_CCCC_0000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 48'h0000_BBBB_0000, 1'b1, 2'd1);
        add(1'b1, 48'h0000_CCCC_0000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 48'h0000_CCCC_0000, 1'b1, 2'd1);
        add(1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 48'h0, 1'b1, 2'd0);
        add(1'b1, 48'h1111_2222_3333, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h1111_2222_3333, 1'b1, 2'd1);
        add(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 48'h1111_BEEF_3333, 1'b1, 2'd1);
        add(1'b1, 48'h4444_5555_6666, 1'b0, 1'b0, 1'b1, 16'hCAFE, 1'b1, 48'h1111_CAFE_3333, 1'b0, 2'd2);
        add(1'b0, 48'h0, 1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b1, 48'h4444_5555_6666, 1'b1, 2'd1);
        add(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, 16'h0123, 1'b1, 48'h4444_0123_6666, 1'b1, 2'd1);
        add(1'b1, 48'h7777_7777_7777, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h4444_0123_6666, 1'b0, 2'd2);
        add(1'b1, 48'h9999_9999_9999, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 48'h0, 1'b1, 2'd0);
        add(1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 48'h0, 1'b1, 2'd0);
        add(1'b1, 48'h55, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h55, 1'b1, 2'd1);
        add(1'b0, 48'h0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 48'h0, 1'b1, 2'd0);
        add(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 48'h0, 1'b1, 2'd0);
        add(1'b1, 48'h77, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 48'h77, 1'b1, 2'd1);
        add(1'b0, 48'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 48'h0, 1'b1, 2'd0);

        for (int i = 0; i < vt.size(); i++) begin
            bus1.up_valid  = vt[i].uv;
            bus1.up_data   = vt[i].d;
            bus1.dn_ready  = vt[i].dr;
            bus1.flush     = vt[i].fl;
            bus1.load_addr = vt[i].ld;
            bus1.next_addr = vt[i].na;
            cyc();
            chk($sformatf("v%0d dn_valid", i), 64'(bus1.dn_valid), 64'(vt[i].e_dv));
            chk($sformatf("v%0d dn_data", i), 64'(bus1.dn_data), 64'(vt[i].e_dd));
            chk($sformatf("v%0d up_ready", i), 64'(bus1.up_ready), 64'(vt[i].e_rdy));
            chk($sformatf("v%0d occupancy", i), 64'(occ1), 64'(vt[i].e_occ));
        end
        bus1.up_valid = 1'b0; bus1.dn_ready = 1'b0; bus1.flush = 1'b0; bus1.load_addr = 1'b0;
        chk("sb drained", 64'(sbq.size()), 64'd0);

        // SKID=0: combinational ready follows dn_ready within the cycle
        bus0.up_valid = 1'b1; bus0.up_data = 48'h12; bus0.dn_ready = 1'b0;
        #1;
        chk("s0 empty up_ready", 64'(bus0.up_ready), 64'd1);
        step0();
        chk("s0 dn_valid", 64'(bus0.dn_valid), 64'd1);
        chk("s0 dn_data", 64'(bus0.dn_data), 64'h12);
        chk("s0 occupancy", 64'(occ0), 64'd1);
        chk("s0 full up_ready", 64'(bus0.up_ready), 64'd0);
        bus0.up_valid = 1'b0; bus0.dn_ready = 1'b1;
        #1;
        chk("s0 same-cycle up_ready", 64'(bus0.up_ready), 64'd1);
        step0();
        chk("s0 drained dn_valid", 64'(bus0.dn_valid), 64'd0);
        chk("s0 drained dn_data", 64'(bus0.dn_data), 64'd0);
        bus0.up_valid = 1'b1; bus0.up_data = 48'h34; bus0.dn_ready = 1'b0;
        step0();
        chk("s0 load 34", 64'(bus0.dn_data), 64'h34);
        bus0.up_data = 48'h56; bus0.dn_ready = 1'b1;
        step0();
        chk("s0 pass-through 56", 64'(bus0.dn_data), 64'h56);
        chk("s0 pass-through occ", 64'(occ0), 64'd1);
        bus0.up_data = 48'h99; bus0.dn_ready = 1'b0;
        step0();
        chk("s0 blocked holds 56", 64'(bus0.dn_data), 64'h56);
        bus0.up_valid = 1'b0; bus0.dn_ready = 1'b1;
        step0();
        chk("s0 final occ", 64'(occ0), 64'd0);
        bus0.dn_ready = 1'b0;

        // long idle: bubble counter must saturate and stay put
        repeat (70000) @(posedge clk);
        #1;
        chk("bubble saturated", 64'(bub1), 64'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("bubble holds", 64'(bub1), 64'hFFFF);
        chk("idle dn_valid", 64'(bus1.dn_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
